// File: rtl/dqsdll_update_ctrl.sv
// DQS DLL update sequencer: waits for stable lock, then issues FREEZE/UDDCNTLN update
// sequences initially, periodically and on request, only while the bus is idle.
module dqsdll_update_ctrl #(
  parameter int LOCK_WAIT    = 16,
  parameter int UPD_INTERVAL = 1024,
  parameter int FREEZE_SETUP = 2,
  parameter int UPD_PULSE    = 2,
  parameter int FREEZE_HOLD  = 2,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       DLL_LOCK,
  input  logic       UPD_REQ,
  input  logic       BUS_IDLE,
  output logic       FREEZE,
  output logic       UDDCNTLN,
  output logic       UPD_BUSY,
  output logic       UPD_DONE,
  output logic       READY,
  output logic [2:0] DBG_STATE
);

  // Handshake: UPD_REQ is a single-cycle strobe (no ready; always accepted, merged into one
  // pending update); BUS_IDLE is a level grant sampled only while waiting to start an update.

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_IDLE      = 3'd1,
    S_WAIT_IDLE = 3'd2,
    S_FRZ       = 3'd3,
    S_UPDATE    = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(FREEZE_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(UPD_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(FREEZE_HOLD - 1);
  localparam logic [CNT_W-1:0] IVL_LOAD     = CNT_W'(UPD_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam bit               PERIODIC_EN  = (UPD_INTERVAL != 0);

  state_t           state, state_nxt;
  logic             lock_meta, lock_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] ivl_cnt, ivl_nxt;
  logic             pend, pend_nxt;
  logic             done_nxt, ready_nxt;
  logic             ivl_expire;

  assign DBG_STATE  = state;
  assign ivl_expire = PERIODIC_EN && (ivl_cnt <= CNT_ONE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= DLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ivl_nxt   = ivl_cnt;
    pend_nxt  = pend;
    done_nxt  = 1'b0;
    ready_nxt = READY;
    if (state != S_WAIT_LOCK && !lock_s) begin
      // Lock loss abandons any sequence in flight without reporting completion.
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = '0;
      ivl_nxt   = '0;
      pend_nxt  = 1'b0;
      ready_nxt = 1'b0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_nxt = '0;
          end else if (cnt == LOCK_LAST) begin
            state_nxt = S_WAIT_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          if (PERIODIC_EN && ivl_cnt != '0) ivl_nxt = ivl_cnt - CNT_ONE;
          if (ivl_expire || UPD_REQ || pend) state_nxt = S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (UPD_REQ) pend_nxt = 1'b1;
          if (BUS_IDLE) begin
            state_nxt = S_FRZ;
            cnt_nxt   = '0;
            pend_nxt  = 1'b0;
          end
        end
        S_FRZ: begin
          if (UPD_REQ) pend_nxt = 1'b1;
          if (cnt == SETUP_LAST) begin
            state_nxt = S_UPDATE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_UPDATE: begin
          if (UPD_REQ) pend_nxt = 1'b1;
          if (cnt == PULSE_LAST) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (UPD_REQ) pend_nxt = 1'b1;
          if (cnt == HOLD_LAST) begin
            state_nxt = (pend || UPD_REQ) ? S_WAIT_IDLE : S_IDLE;
            cnt_nxt   = '0;
            ivl_nxt   = IVL_LOAD;
            done_nxt  = 1'b1;
            ready_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_WAIT_LOCK;
      cnt      <= '0;
      ivl_cnt  <= '0;
      pend     <= 1'b0;
      FREEZE   <= 1'b0;
      UDDCNTLN <= 1'b1;
      UPD_BUSY <= 1'b0;
      UPD_DONE <= 1'b0;
      READY    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ivl_cnt  <= ivl_nxt;
      pend     <= pend_nxt;
      FREEZE   <= (state_nxt == S_FRZ) || (state_nxt == S_UPDATE) || (state_nxt == S_RELEASE);
      UDDCNTLN <= (state_nxt != S_UPDATE);
      UPD_BUSY <= (state_nxt == S_WAIT_IDLE) || (state_nxt == S_FRZ) ||
                  (state_nxt == S_UPDATE) || (state_nxt == S_RELEASE);
      UPD_DONE <= done_nxt;
      READY    <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_dqsdll_update_ctrl.sv
// Directed bench for dqsdll_update_ctrl: initial lock, periodic, deferral, merge,
// lock loss and asynchronous reset, with a FREEZE/UDDCNTLN invariant monitor.
module tb_dqsdll_update_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RSTN, DLL_LOCK, UPD_REQ, BUS_IDLE;
  logic       FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY;
  logic [2:0] dbg_state;

  logic       rstn_o, lock_o, req_o, bus_o;
  logic       freeze_o, udd_o, busy_o, done_o, ready_o;
  logic [2:0] dbg_o;

  int  checks = 0;
  int  passes = 0;
  bit  inv_en = 1'b0;

  dqsdll_update_ctrl #(
    .LOCK_WAIT(4), .UPD_INTERVAL(20), .FREEZE_SETUP(2), .UPD_PULSE(2), .FREEZE_HOLD(2),
    .CNT_W(16)
  ) u_dut (
    .CLK(CLK), .RSTN(RSTN), .DLL_LOCK(DLL_LOCK), .UPD_REQ(UPD_REQ), .BUS_IDLE(BUS_IDLE),
    .FREEZE(FREEZE), .UDDCNTLN(UDDCNTLN), .UPD_BUSY(UPD_BUSY), .UPD_DONE(UPD_DONE),
    .READY(READY), .DBG_STATE(dbg_state)
  );

  dqsdll_update_ctrl #(
    .LOCK_WAIT(4), .UPD_INTERVAL(0), .FREEZE_SETUP(2), .UPD_PULSE(2), .FREEZE_HOLD(2),
    .CNT_W(16)
  ) u_off (
    .CLK(CLK), .RSTN(rstn_o), .DLL_LOCK(lock_o), .UPD_REQ(req_o), .BUS_IDLE(bus_o),
    .FREEZE(freeze_o), .UDDCNTLN(udd_o), .UPD_BUSY(busy_o), .UPD_DONE(done_o),
    .READY(ready_o), .DBG_STATE(dbg_o)
  );

  // UDDCNTLN low is only legal while FREEZE is high.
  always @(negedge CLK) begin
    if (inv_en) begin
      checks++;
      if ((UDDCNTLN === 1'b0 && FREEZE !== 1'b1) || (udd_o === 1'b0 && freeze_o !== 1'b1))
        $display("FAIL invariant t=%0t: dut F=%b U=%b off F=%b U=%b required F=1 when U=0",
                 $time, FREEZE, UDDCNTLN, freeze_o, udd_o);
      else passes++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE} k edges after entering WAIT_IDLE (k<0: idle).
  function automatic logic [3:0] exp_seq(input int k);
    logic f, u, b, d;
    f = (k >= 1) && (k <= 6);
    u = !((k == 3) || (k == 4));
    b = (k >= 0) && (k <= 6);
    d = (k == 7);
    return {f, u, b, d};
  endfunction

  task automatic bring_up();
    RSTN = 1'b0; DLL_LOCK = 1'b0; UPD_REQ = 1'b0; BUS_IDLE = 1'b1;
    tick(); tick();
    RSTN = 1'b1; DLL_LOCK = 1'b1;
    for (int e = 1; e <= 14; e++) tick();
  endtask

  task automatic test_reset();
    RSTN = 1'b0; DLL_LOCK = 1'b0; UPD_REQ = 1'b0; BUS_IDLE = 1'b1;
    tick(); tick();
    checks++;
    if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY} !== 5'b01000)
      $display("FAIL reset_values: got %b required 01000",
               {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY});
    else passes++;
    inv_en = 1'b1;
  endtask

  task automatic test_initial_lock(input string tag);
    logic [4:0] exp;
    RSTN = 1'b1; DLL_LOCK = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp = {exp_seq(e - 6), (e >= 13)};
      checks++;
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY} !== exp)
        $display("FAIL %s edge %0d: got FUBDR=%b required %b", tag, e,
                 {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY}, exp);
      else passes++;
    end
  endtask

  task automatic test_periodic();
    logic [4:0] exp;
    for (int e = 15; e <= 40; e++) begin
      tick();
      exp = {exp_seq(e - 33), 1'b1};
      checks++;
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY} !== exp)
        $display("FAIL periodic edge %0d: got FUBDR=%b required %b", e,
                 {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY}, exp);
      else passes++;
    end
  endtask

  task automatic test_periodic_off();
    int busy_cycles;
    rstn_o = 1'b1; lock_o = 1'b1;
    for (int e = 1; e <= 14; e++) tick();
    checks++;
    if (ready_o !== 1'b1) $display("FAIL off_initial_ready: got %b required 1", ready_o);
    else passes++;
    busy_cycles = 0;
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (busy_o !== 1'b0 || done_o !== 1'b0 || freeze_o !== 1'b0) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0)
      $display("FAIL periodic_off: got %0d busy cycles in 5000 required 0", busy_cycles);
    else passes++;
  endtask

  task automatic test_bus_deferral();
    int bad;
    logic [3:0] exp;
    bring_up();
    BUS_IDLE = 1'b0;
    bad = 0;
    for (int e = 15; e <= 132; e++) begin
      tick();
      if (e >= 33 && (UPD_BUSY !== 1'b1 || FREEZE !== 1'b0 || UDDCNTLN !== 1'b1)) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL bus_deferral_hold: got %0d bad cycles required 0", bad);
    else passes++;
    BUS_IDLE = 1'b1;
    for (int e = 133; e <= 139; e++) begin
      tick();
      exp = exp_seq(e - 132);
      checks++;
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE} !== exp)
        $display("FAIL bus_deferral_release edge %0d: got FUBD=%b required %b", e,
                 {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE}, exp);
      else passes++;
    end
  endtask

  task automatic test_request_merge();
    int bad;
    logic [3:0] exp;
    bring_up();
    for (int e = 15; e <= 29; e++) begin
      UPD_REQ = (e == 15) || (e == 19) || (e == 20) || (e == 21);
      tick();
      if (e <= 22) begin
        exp = exp_seq(e - 15);
        if (e == 22) exp[1] = 1'b1;
      end else begin
        exp = exp_seq(e - 22);
      end
      checks++;
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE} !== exp)
        $display("FAIL merge edge %0d: got FUBD=%b required %b", e,
                 {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE}, exp);
      else passes++;
    end
    UPD_REQ = 1'b0;
    for (int e = 30; e <= 56; e++) begin
      UPD_REQ = (e == 49);
      tick();
      exp = exp_seq(e - 49);
      checks++;
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE} !== exp)
        $display("FAIL coincident edge %0d: got FUBD=%b required %b", e,
                 {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE}, exp);
      else passes++;
    end
    UPD_REQ = 1'b0;
    bad = 0;
    for (int e = 57; e <= 66; e++) begin
      tick();
      if (UPD_BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL coincident_single: got %0d busy cycles required 0", bad);
    else passes++;
  endtask

  task automatic test_lock_loss();
    int bad;
    logic [4:0] exp;
    bring_up();
    for (int e = 15; e <= 19; e++) begin
      UPD_REQ = (e == 15);
      if (e == 17) DLL_LOCK = 1'b0;
      tick();
      exp = (e == 19) ? 5'b01000 : {exp_seq(e - 15), 1'b1};
      checks++;
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY} !== exp)
        $display("FAIL lock_loss edge %0d: got FUBDR=%b required %b", e,
                 {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY}, exp);
      else passes++;
    end
    UPD_REQ = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY} !== 5'b01000) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL lock_loss_quiet: got %0d bad cycles required 0", bad);
    else passes++;
    test_initial_lock("relock");
  endtask

  task automatic test_async_reset();
    bring_up();
    UPD_REQ = 1'b1;
    tick();
    UPD_REQ = 1'b0;
    tick();
    checks++;
    if (FREEZE !== 1'b1) $display("FAIL async_pre_freeze: got %b required 1", FREEZE);
    else passes++;
    #3;
    RSTN = 1'b0;
    #1;
    checks++;
    if ({FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY} !== 5'b01000)
      $display("FAIL async_reset: got FUBDR=%b required 01000",
               {FREEZE, UDDCNTLN, UPD_BUSY, UPD_DONE, READY});
    else passes++;
    tick();
    RSTN = 1'b1;
    tick();
  endtask

  initial begin
    rstn_o = 1'b0; lock_o = 1'b0; req_o = 1'b0; bus_o = 1'b1;
    test_reset();
    test_initial_lock("initial_lock");
    test_periodic();
    test_periodic_off();
    test_bus_deferral();
    test_request_merge();
    test_lock_loss();
    test_async_reset();
    inv_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
